// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int CNT_W_DEF      = 20;
  localparam int PERIOD_RST_DEF = 999_999;  // 20 ms at 50 MHz

  // Write-address width: channels 0..NCH-1 plus the period register at NCH.
  function automatic int calc_aw(input int nch);
    return $clog2(nch + 1);
  endfunction

  // Address of the period shadow register.
  function automatic int addr_period(input int nch);
    return nch;
  endfunction

endpackage

// File: rtl/pwm_servo_channel.sv
// One PWM channel: duty shadow/active registers, enable latch and registered comparator.
// Latency: pwm_o follows the shared counter by one cycle.
// Backpressure: none; writes are always accepted into the shadow register.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   enable     global run; low forces the output low
//   load       transfer shadow -> active (period boundary, or every cycle while disabled)
//   wr         write strobe for this channel's duty shadow
//   wr_data    duty value to write
//   ch_en_i    channel enable, captured into the active copy on load
//   counter    shared period counter
//   pwm_o      registered PWM output
module pwm_servo_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             ch_en_i,
  input  logic [CNT_W-1:0] counter,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_sh_q,  duty_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             ch_en_act_q, ch_en_act_d;
  logic             pwm_q,       pwm_d;

  always_comb begin
    duty_sh_d   = duty_sh_q;
    duty_act_d  = duty_act_q;
    ch_en_act_d = ch_en_act_q;
    if (wr) begin
      duty_sh_d = wr_data;
    end
    // The active copy takes the shadow's current value, so a write landing
    // on the same edge as a load only takes effect at the following load.
    if (load) begin
      duty_act_d  = duty_sh_q;
      ch_en_act_d = ch_en_i;
    end
    // duty >= period+1 never sees counter reach it, giving a constant high.
    pwm_d = enable && ch_en_act_q && (counter < duty_act_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q   <= '0;
      duty_act_q  <= '0;
      ch_en_act_q <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      duty_sh_q   <= duty_sh_d;
      duty_act_q  <= duty_act_d;
      ch_en_act_q <= ch_en_act_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_servo_multi.sv
// Multi-channel servo PWM: one shared period counter, NCH duty comparators, boundary-applied shadows.
// Latency: pwm/period_start are registered, one cycle after the counter value they reflect.
// Backpressure: none; register writes are accepted every cycle, including while disabled.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   enable        global run; low holds counter at 0 and forces outputs low
//   wr_en         single-cycle write strobe
//   wr_addr       0..NCH-1 duty registers, NCH period register, others ignored
//   wr_data       write value
//   ch_en         per-channel enable, captured at period boundaries
//   pwm           registered PWM outputs
//   period_start  one-cycle pulse aligned with the first pwm cycle of each period
module pwm_servo_multi
  import pwm_pkg::*;
#(
  parameter int               NCH        = 4,
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(PERIOD_RST_DEF),
  parameter int               AW         = calc_aw(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   pwm,
  output logic             period_start
);

  localparam logic [AW-1:0] ADDR_PERIOD = AW'(addr_period(NCH));

  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] period_sh_q,  period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic             period_start_q, period_start_d;
  logic             boundary;
  logic             load;

  always_comb begin
    boundary = enable && (cnt_q == period_act_q);
    // While disabled the active set tracks the shadows so re-enable starts
    // with the latest settings.
    load = boundary || !enable;

    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || boundary) begin
      cnt_d = '0;
    end

    period_sh_d = period_sh_q;
    if (wr_en && (wr_addr == ADDR_PERIOD)) begin
      period_sh_d = wr_data;
    end

    period_act_d = period_act_q;
    if (load) begin
      period_act_d = period_sh_q;
    end

    period_start_d = enable && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      period_sh_q    <= PERIOD_RST;
      period_act_q   <= PERIOD_RST;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_sh_q    <= period_sh_d;
      period_act_q   <= period_act_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_servo_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .load    (load),
      .wr      (wr_en && (wr_addr == AW'(i))),
      .wr_data (wr_data),
      .ch_en_i (ch_en[i]),
      .counter (cnt_q),
      .pwm_o   (pwm[i])
    );
  end

endmodule

// File: doc/pwm_servo_multi.md
Name: pwm_servo_multi

Overview:
- Multi-channel successor to the single-channel servo PWM.
- One shared period counter drives NCH independent duty comparators.
- Each channel has its own duty register and enable.
- Period and duty writes land in shadow registers and are applied only at period boundaries, so every output pulse is glitch-free.
- Sits between the CPU/register bus and the servo pins; it replaces per-servo PWM instances.

Parameters:
- NCH, 4, number of PWM channels (1..16).
- CNT_W, 20, width of the period counter, the period register and the duty registers.
- PERIOD_RST, 20'd999_999, period value loaded at reset (20 ms at 50 MHz: 1,000,000 cycles).
- AW, $clog2(NCH+1), write-address width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global run; low holds the counter at 0 and forces all outputs low.
- wr_en  in  1  single-cycle write strobe.
- wr_addr  in  AW  0..NCH-1 selects a channel duty register; NCH selects the period register; other values are ignored.
- wr_data  in  CNT_W  value to write.
- ch_en  in  NCH  per-channel enable, sampled at the boundary together with the shadows.
- pwm  out  NCH  PWM outputs, registered.
- period_start  out  1  one-cycle pulse in the cycle the counter is 0 while running.

Behaviour:
- Reset (rst=1 at a posedge):
  - counter=0, period_sh=period_act=PERIOD_RST.
  - all duty_sh/duty_act=0, ch_en_act=0.
  - pwm=0, period_start=0.
  - Reset mid-period aborts the period immediately; there is no partial pulse.
- Counter (when enable=1): if counter==period_act then counter<=0, else counter<=counter+1.
  - Period length is period_act+1 cycles.
  - period_act=0 gives a 1-cycle period.
- Boundary: the cycle where counter==period_act and enable=1.
  - On the following edge, period_act<=period_sh, duty_act[i]<=duty_sh[i], ch_en_act<=ch_en.
- Writes: with wr_en=1, the shadow register at wr_addr takes wr_data on the next edge.
  - A write in the same cycle as a boundary is not loaded at that boundary; the old shadow value is transferred and the new value applies at the next boundary.
- enable=0:
  - counter<=0, pwm<=0, period_start<=0.
  - Active registers load from the shadows every cycle, so new settings are live immediately on re-enable.
  - Writes are still accepted.
- Output timing (pwm[i] <= enable && ch_en_act[i] && (counter < duty_act[i])):
  - pwm is high for exactly duty_act[i] cycles per period, starting one cycle after counter==0.
- Duty edge cases:
  - duty_act=0 gives a constant low.
  - duty_act >= period_act+1 gives a constant high (100%, no low cycle).
- period_start <= enable && (counter==0), i.e. aligned with the first pwm cycle of each period.
- Arithmetic:
  - All comparisons are unsigned CNT_W.
  - The counter never exceeds period_act, so no wrap beyond 2^CNT_W-1 is possible.
- Enable falling mid-period: outputs go low on the next edge and the counter restarts at 0 on re-enable. A truncated pulse is permitted only at the disable instant.

Decomposition:
- Package pwm_pkg:
  - CNT_W default.
  - PERIOD_RST.
  - Address constant ADDR_PERIOD = NCH.
  - Function for AW.
- Sub-module pwm_servo_channel (one per channel, generate loop): contains duty_sh, duty_act, ch_en_act and the registered comparator.
  - Inputs: clk, rst, enable, load, wr, wr_data, ch_en_i, counter.
- The top holds the counter, period_sh/period_act, address decode and period_start.

Test Plan:
1. Basic PWM: NCH=4, CNT_W=8. Reset, write period=9 and duty0=3, ch_en=4'b0001, enable=1. Expect pwm[0] high 3 of every 10 cycles, period_start every 10 cycles, pwm[3:1]=0.
2. Shadowing: while running with period=9 and duty0=3, write duty0=7 at counter=4. Expect the current period still shows a 3-cycle pulse and the next period shows 7; no pulse is stretched or cut.
3. Boundary collision: write duty0=5 exactly in the cycle counter==9. Expect the next period still uses the old duty and the period after that uses 5.
4. Extremes: duty0=0 gives pwm[0] constantly 0. duty1=10 and duty1=255 with period=9 each give pwm[1] constantly 1. period=0 with duty=1 gives constant high and period_start every cycle.
5. Enable/reset mid-period: drop enable at counter=2 while pwm is high. Expect pwm=0 on the next edge and counter=0. Re-enable and expect a full-length first pulse. Repeat the sequence with rst=1 instead of dropping enable, and expect duties cleared to 0 and period back to PERIOD_RST.
6. Multi-channel plus invalid address: set duties 1, 2, 3, 4 on channels 0-3 and write to address 5 (invalid). Expect four independent pulse widths of 1, 2, 3 and 4 cycles, all rising in the same cycle, and no register changed by the invalid write.
